// File: rtl/i2s_tx_64x.sv
// -----------------------------------------------------------------------------
// i2s_tx_64x
// Stereo Philips I2S transmitter, 64 bclk per frame (32 per channel).
// One left/right pair is buffered behind a valid/ready handshake. At each
// frame boundary the buffered pair moves into the shift registers and is sent
// MSB first, one bclk after each lrclk transition. If no pair is waiting
// when a frame starts, the frame carries zeros and underrun pulses.
// All state changes on the falling edge of bclk, so a receiver that samples
// on the rising edge gets half a period of setup and hold.
//
// Ports:
//   bclk        in   bit clock (state advances on falling edge)
//   rst         in   asynchronous reset, active low
//   left_in     in   [DATA_WIDTH] left sample, two's complement
//   right_in    in   [DATA_WIDTH] right sample, two's complement
//   in_valid    in   left_in/right_in hold a valid pair
//   in_ready    out  holding buffer empty
//   lrclk       out  word select, 0 = left slot, 1 = right slot
//   sdout       out  serial data, MSB first
//   frame_start out  one-bclk pulse in the first period of each frame
//   underrun    out  one-bclk pulse with frame_start when no pair was buffered
// -----------------------------------------------------------------------------
module i2s_tx_64x #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  bclk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] left_in,
  input  logic [DATA_WIDTH-1:0] right_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  lrclk,
  output logic                  sdout,
  output logic                  frame_start,
  output logic                  underrun
);

  // Position of the last data bit inside a 32-bit slot (slot offset 1..DATA_WIDTH).
  localparam logic [4:0] LAST_BIT = 5'(DATA_WIDTH);

  logic [5:0]            cnt_q,   cnt_d;
  logic                  full_q,  full_d;
  logic [DATA_WIDTH-1:0] buf_l_q, buf_l_d;
  logic [DATA_WIDTH-1:0] buf_r_q, buf_r_d;
  logic [DATA_WIDTH-1:0] sh_l_q,  sh_l_d;
  logic [DATA_WIDTH-1:0] sh_r_q,  sh_r_d;
  logic                  lrclk_q, lrclk_d;
  logic                  sdout_q, sdout_d;
  logic                  fs_q,    fs_d;
  logic                  ur_q,    ur_d;

  logic                  load_s;
  logic                  accept_s;
  logic                  left_slot_s;
  logic                  right_slot_s;

  // Ready depends only on the registered flag; no path from in_valid.
  assign in_ready    = !full_q;
  assign lrclk       = lrclk_q;
  assign sdout       = sdout_q;
  assign frame_start = fs_q;
  assign underrun    = ur_q;

  // Next-state logic. Outputs are computed from the count value the edge is
  // about to enter, so each registered output belongs to the period cnt_d.
  always_comb begin
    cnt_d        = cnt_q + 6'd1;
    load_s       = (cnt_q == 6'd63);
    accept_s     = in_valid && !full_q;
    left_slot_s  = !cnt_d[5] && (cnt_d[4:0] != 5'd0) && (cnt_d[4:0] <= LAST_BIT);
    right_slot_s =  cnt_d[5] && (cnt_d[4:0] != 5'd0) && (cnt_d[4:0] <= LAST_BIT);

    full_d  = full_q;
    buf_l_d = buf_l_q;
    buf_r_d = buf_r_q;
    sh_l_d  = sh_l_q;
    sh_r_d  = sh_r_q;
    sdout_d = 1'b0;
    lrclk_d = cnt_d[5];
    fs_d    = load_s;
    ur_d    = 1'b0;

    if (load_s) begin
      // Frame boundary: drain the buffer, or send silence if it is empty.
      // Slot offset 0 is the I2S one-bit delay, so sdout stays 0 here.
      if (full_q) begin
        sh_l_d = buf_l_q;
        sh_r_d = buf_r_q;
        full_d = 1'b0;
      end else begin
        sh_l_d = {DATA_WIDTH{1'b0}};
        sh_r_d = {DATA_WIDTH{1'b0}};
        ur_d   = 1'b1;
      end
    end else if (left_slot_s) begin
      sdout_d = sh_l_q[DATA_WIDTH-1];
      sh_l_d  = {sh_l_q[DATA_WIDTH-2:0], 1'b0};
    end else if (right_slot_s) begin
      sdout_d = sh_r_q[DATA_WIDTH-1];
      sh_r_d  = {sh_r_q[DATA_WIDTH-2:0], 1'b0};
    end else begin
      sdout_d = 1'b0;
    end

    // Accept can only coincide with a load when the buffer is already empty,
    // so the new pair is held for the next frame and this one still underruns.
    if (accept_s) begin
      buf_l_d = left_in;
      buf_r_d = right_in;
      full_d  = 1'b1;
    end else begin
      buf_l_d = buf_l_q;
      buf_r_d = buf_r_q;
    end
  end

  // State register: falling-edge bclk, asynchronous active-low reset.
  always_ff @(negedge bclk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= 6'd63;
      full_q  <= 1'b0;
      buf_l_q <= {DATA_WIDTH{1'b0}};
      buf_r_q <= {DATA_WIDTH{1'b0}};
      sh_l_q  <= {DATA_WIDTH{1'b0}};
      sh_r_q  <= {DATA_WIDTH{1'b0}};
      lrclk_q <= 1'b0;
      sdout_q <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      buf_l_q <= buf_l_d;
      buf_r_q <= buf_r_d;
      sh_l_q  <= sh_l_d;
      sh_r_q  <= sh_r_d;
      lrclk_q <= lrclk_d;
      sdout_q <= sdout_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
    end
  end

endmodule

// File: tb/tb_i2s_tx_64x.sv
// -----------------------------------------------------------------------------
// tb_i2s_tx_64x
// Directed bench for i2s_tx_64x (DATA_WIDTH = 16). Inputs are driven and
// outputs sampled on the rising bclk edge, opposite to the DUT's active edge.
// A receiver process deserialises each frame so transmitted pairs can be
// compared with the pairs the bench handed over.
// -----------------------------------------------------------------------------
module tb_i2s_tx_64x;

  logic        bclk;
  logic        rst;
  logic [15:0] left_in;
  logic [15:0] right_in;
  logic        in_valid;
  logic        in_ready;
  logic        lrclk;
  logic        sdout;
  logic        frame_start;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;

  // Receiver state
  int          mon_k = 99;
  logic [15:0] asm_l, asm_r;
  logic        asm_u;
  logic [15:0] mon_l[$];
  logic [15:0] mon_r[$];
  logic        mon_u[$];
  int          ur_stray = 0;

  // Scoreboard of accepted pairs
  logic [15:0] exp_l[$];
  logic [15:0] exp_r[$];

  i2s_tx_64x #(.DATA_WIDTH(16)) dut (
    .bclk        (bclk),
    .rst         (rst),
    .left_in     (left_in),
    .right_in    (right_in),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .lrclk       (lrclk),
    .sdout       (sdout),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to the rising edge of the next period that carries frame_start.
  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    @(posedge bclk);
    while (frame_start !== 1'b1 && n < 70) begin
      @(posedge bclk);
      n++;
    end
    if (frame_start !== 1'b1) check_val(tag, 32'(frame_start), 32'd1);
  endtask

  // Receiver: sample on rising bclk, rebuild each frame's pair.
  always @(posedge bclk) begin
    if (!rst) begin
      mon_k = 99;
    end else begin
      if (frame_start) mon_k = 0;
      else if (mon_k < 99) mon_k++;
      if (underrun && !frame_start) ur_stray++;
      if (mon_k == 0) asm_u = underrun;
      if (mon_k >= 1 && mon_k <= 16) asm_l = {asm_l[14:0], sdout};
      if (mon_k >= 33 && mon_k <= 48) asm_r = {asm_r[14:0], sdout};
      if (mon_k == 63) begin
        mon_l.push_back(asm_l);
        mon_r.push_back(asm_r);
        mon_u.push_back(asm_u);
      end
    end
  end

  initial begin
    logic [63:0] exp_sd;
    int acc;
    int nd;

    rst = 1'b0; in_valid = 1'b0; left_in = 16'd0; right_in = 16'd0;

    // ---- Reset values ----
    repeat (3) @(posedge bclk);
    check_val("rst_in_ready", 32'(in_ready),    32'd1);
    check_val("rst_lrclk",    32'(lrclk),       32'd0);
    check_val("rst_sdout",    32'(sdout),       32'd0);
    check_val("rst_fs",       32'(frame_start), 32'd0);
    check_val("rst_ur",       32'(underrun),    32'd0);
    rst = 1'b1;
    wait_fs("to_first_fs");
    check_val("first_fs",       32'(frame_start), 32'd1);
    check_val("first_ur",       32'(underrun),    32'd1);
    check_val("first_lrclk",    32'(lrclk),       32'd0);
    check_val("first_in_ready", 32'(in_ready),    32'd1);

    // ---- Bit placement: 0x8001 / 0x7FFE ----
    left_in = 16'h8001; right_in = 16'h7FFE; in_valid = 1'b1;
    @(posedge bclk);
    check_val("bp_accept_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_fs("to_bit_frame");
    check_val("bit_frame_ur",    32'(underrun), 32'd0);
    check_val("bit_frame_ready", 32'(in_ready), 32'd1);
    exp_sd = 64'd0;
    exp_sd[1]  = 1'b1;
    exp_sd[16] = 1'b1;
    for (int j = 34; j <= 47; j++) exp_sd[j] = 1'b1;
    for (int k = 0; k < 64; k++) begin
      check_val($sformatf("sdout_k%0d", k), 32'(sdout), 32'(exp_sd[k]));
      check_val($sformatf("lrclk_k%0d", k), 32'(lrclk), (k >= 32) ? 32'd1 : 32'd0);
      @(posedge bclk);
    end
    check_val("idle_fs", 32'(frame_start), 32'd1);
    check_val("idle_ur", 32'(underrun),    32'd1);

    // ---- Underrun: A, skip, B ----
    mon_l.delete(); mon_r.delete(); mon_u.delete();
    left_in = 16'h1234; right_in = 16'hABCD; in_valid = 1'b1;
    @(posedge bclk);
    in_valid = 1'b0;
    wait_fs("to_frame_a");
    wait_fs("to_skip_frame");
    check_val("skip_ur", 32'(underrun), 32'd1);
    left_in = 16'h5A5A; right_in = 16'hC3C3; in_valid = 1'b1;
    @(posedge bclk);
    in_valid = 1'b0;
    wait_fs("to_frame_b");
    wait_fs("after_frame_b");
    check_val("ur_frames", 32'(mon_l.size()), 32'd4);
    if (mon_l.size() == 4) begin
      check_val("ur_f1_u", 32'(mon_u[1]), 32'd0);
      check_val("ur_f1_l", 32'(mon_l[1]), 32'h1234);
      check_val("ur_f1_r", 32'(mon_r[1]), 32'hABCD);
      check_val("ur_f2_u", 32'(mon_u[2]), 32'd1);
      check_val("ur_f2_l", 32'(mon_l[2]), 32'h0000);
      check_val("ur_f2_r", 32'(mon_r[2]), 32'h0000);
      check_val("ur_f3_u", 32'(mon_u[3]), 32'd0);
      check_val("ur_f3_l", 32'(mon_l[3]), 32'h5A5A);
      check_val("ur_f3_r", 32'(mon_r[3]), 32'hC3C3);
    end

    // ---- Boundary: valid first on the wrap edge ----
    repeat (63) @(posedge bclk);
    check_val("bnd_ready_pre", 32'(in_ready), 32'd1);
    left_in = 16'h0F0F; right_in = 16'hF0F0; in_valid = 1'b1;
    @(posedge bclk);
    check_val("bnd_fs",    32'(frame_start), 32'd1);
    check_val("bnd_ur",    32'(underrun),    32'd1);
    check_val("bnd_ready", 32'(in_ready),    32'd0);
    in_valid = 1'b0;
    mon_l.delete(); mon_r.delete(); mon_u.delete();
    wait_fs("to_bnd_frame");
    check_val("bnd_next_ur", 32'(underrun), 32'd0);
    wait_fs("after_bnd_frame");
    check_val("bnd_frames", 32'(mon_l.size()), 32'd2);
    if (mon_l.size() == 2) begin
      check_val("bnd_f0_zero_l", 32'(mon_l[0]), 32'h0000);
      check_val("bnd_f1_l",      32'(mon_l[1]), 32'h0F0F);
      check_val("bnd_f1_r",      32'(mon_r[1]), 32'hF0F0);
    end

    // ---- Back-pressure / loopback: 256 random pairs, valid held high ----
    mon_l.delete(); mon_r.delete(); mon_u.delete();
    exp_l.delete(); exp_r.delete();
    acc = 0;
    for (int c = 0; c < 256 * 64; c++) begin
      left_in  = 16'($urandom_range(0, 65535));
      right_in = 16'($urandom_range(0, 65535));
      in_valid = 1'b1;
      check_val("bp_ready", 32'(in_ready), ((c % 64) == 0) ? 32'd1 : 32'd0);
      if (in_ready) begin
        exp_l.push_back(left_in);
        exp_r.push_back(right_in);
        acc++;
      end
      @(posedge bclk);
    end
    in_valid = 1'b0;
    check_val("bp_accepts", 32'(acc), 32'd256);
    wait_fs("bp_drain");
    nd = 0;
    foreach (mon_l[i]) begin
      if (!mon_u[i]) begin
        if (nd < exp_l.size()) begin
          check_val("lb_left",  32'(mon_l[i]), 32'(exp_l[nd]));
          check_val("lb_right", 32'(mon_r[i]), 32'(exp_r[nd]));
        end
        nd++;
      end
    end
    check_val("lb_count", 32'(nd), 32'd256);

    // ---- Reset mid-frame with buffer full and sdout active ----
    left_in = 16'hFFFF; right_in = 16'hFFFF; in_valid = 1'b1;
    @(posedge bclk);
    in_valid = 1'b0;
    wait_fs("to_rst_frame");
    left_in = 16'h1111; right_in = 16'h2222; in_valid = 1'b1;
    @(posedge bclk);
    in_valid = 1'b0;
    check_val("mr_full", 32'(in_ready), 32'd0);
    repeat (33) @(posedge bclk);
    check_val("mr_sdout_pre", 32'(sdout), 32'd1);
    check_val("mr_lrclk_pre", 32'(lrclk), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("mr_in_ready", 32'(in_ready),    32'd1);
    check_val("mr_sdout",    32'(sdout),       32'd0);
    check_val("mr_lrclk",    32'(lrclk),       32'd0);
    check_val("mr_fs",       32'(frame_start), 32'd0);
    check_val("mr_ur",       32'(underrun),    32'd0);
    repeat (2) @(posedge bclk);
    rst = 1'b1;
    wait_fs("mr_first_fs");
    check_val("mr_first_ur",    32'(underrun), 32'd1);
    check_val("mr_first_ready", 32'(in_ready), 32'd1);
    wait_fs("mr_second_fs");
    check_val("mr_discard_ur",  32'(underrun), 32'd1);

    check_val("ur_stray", 32'(ur_stray), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
